modulo_batalha_naval_param: RTL and testbench
=============================================

// Module: modulo_batalha_naval_param
// PURPOSE
//  Parametrised naval-battle board engine: stores ship positions and attacks on a ROWS x COLS grid.
//  Resolves each confirmed attack as hit/miss/invalid and counts remaining ship cells.
//  Drives the multiplexed LED matrix directly, scanning one column at a time.
//  Sits between the switch/button inputs and the LED matrix; replaces the fixed 7x5 register/demux/mux array.
// PARAMETERS
//  ROWS       7   grid lines (matrix rows), >=2
//  COLS       5   grid columns, >=2
//  MAX_SHIPS  9   max ship cells that may be placed, 1..ROWS*COLS
//  SCAN_DIV   16  clk cycles per displayed column, >=1
// PORTS
//  clk        in   1                     system clock; all logic on rising edge
//  Nclr       in   1                     synchronous reset, active-low
//  mode       in   2                     00 idle/clear, 01 place, 10 attack, 11 hold
//  lin_sel    in   $clog2(ROWS)          target line index
//  col_sel    in   $clog2(COLS)          target column index
//  confirm    in   1                     async push-button, active-high
//  m_col      out  COLS                  column drive, one-hot, active-high
//  m_line     out  ROWS                  line drive, active-low (1 = LED off)
//  result     out  2                     00 none, 01 miss, 10 hit, 11 invalid
//  hits_left  out  $clog2(ROWS*COLS+1)   ship cells not yet hit
//  state      out  2                     00 IDLE, 01 PLACE, 10 ATTACK, 11 OVER
//  game_over  out  1                     1 while state==OVER
// BEHAVIOUR
//  - Reset (Nclr=0 at edge): state=IDLE; pos/atk matrices=0; hits_left=0; result=00; game_over=0.
//    Also at reset: scan column=0; m_col=1 (col 0 driven); m_line=all 1; prescaler=0; sync regs=0.
//  - confirm passes through a 2-FF synchroniser, then a third FF for edge detection.
//  - Edge pulse = s2 & ~s3. A press first sampled at edge N takes effect at edge N+2.
//  - A held button gives exactly one pulse.
//  - FSM, evaluated each edge. Mode-driven transitions take priority; a pulse arriving with a transition is dropped.
//    IDLE: pos=0, atk=0, hits_left=0, result=00 every cycle. mode==01 -> PLACE.
//    PLACE: a pulse with an in-range, unset cell sets pos[l][c], increments hits_left, result=00.
//      Pulse with an out-of-range index, an already-set cell, or hits_left==MAX_SHIPS -> result=11, no change.
//      mode==10 and hits_left>0 -> ATTACK (result=00). mode==00 -> IDLE. Otherwise stay.
//    ATTACK: a pulse with an in-range, unattacked cell sets atk[l][c].
//      If pos set: result=10 and hits_left decrements. Else: result=01.
//      A hit bringing hits_left 1->0 moves to OVER on the same edge.
//      Repeat cell or out-of-range index -> result=11, no change. mode==00 -> IDLE.
//    OVER: matrices frozen; pulses ignored; result holds. mode==00 -> IDLE.
//  - result holds its last value until the next pulse or the next IDLE entry.
//  - Scan: prescaler counts 0..SCAN_DIV-1. At wrap, the column index advances and wraps COLS-1 -> 0.
//    m_col is registered and one-hot of the column index.
//    m_line[l] is registered and shows the current column:
//      = ~pos[l][c] in PLACE/IDLE
//      = ~atk[l][c] in ATTACK/OVER
//    m_col and m_line change on the same edge; they are never mismatched by one cycle.
//  - Reset mid-game: all storage is lost, same as the reset values above.
// CONFIGURATION
//  BLINK_HITS_EN defined:
//    In ATTACK/OVER, cells with atk&pos blink. They are lit only while a free-running 20-bit counter bit[19]==1.
//    Misses stay steady-lit.
//  BLINK_HITS_EN undefined: hits and misses are both steady-lit; no 20-bit counter is instantiated.
// TESTING
//  1 Nclr=0 for 2 cycles -> state=00, m_col=...0001, m_line=all 1, hits_left=0, result=00.
//  2 PLACE (1,2) and (3,4), then press (1,2) again -> hits_left=2, third result=11, pos unchanged.
//  3 ATTACK (0,0) -> result=01. Attack (1,2) -> result=10, hits_left=1. Attack (1,2) again -> result=11.
//  4 Attack (3,4) -> result=10, hits_left=0, state=11, game_over=1. Further presses leave all outputs unchanged.
//  5 SCAN_DIV=4, COLS=5 -> m_col advances every 4 cycles, returns to col 0 after 20 cycles, m_line matches pos column.
//  6 Press held 50 cycles -> exactly one action. Press on the same edge mode goes 01->00 -> state=IDLE, no placement.

Source files
------------

// File: rtl/modulo_batalha_naval_param.sv
// ---------------------------------------------------------------------------
// modulo_batalha_naval_param
// Parametrised naval-battle board engine. Stores ship positions and attacks on
// a ROWS x COLS grid, resolves each confirmed attack as hit/miss/invalid,
// tracks the ship cells still standing and scans the LED matrix one column
// at a time.
//
// Optional feature macro: BLINK_HITS_EN (hit cells blink in ATTACK/OVER).
//
// Ports
//   clk        system clock, rising edge
//   Nclr       synchronous reset, active-low
//   mode       00 idle/clear, 01 place, 10 attack, 11 hold
//   lin_sel    target line index
//   col_sel    target column index
//   confirm    asynchronous push-button, active-high
//   m_col      column drive, one-hot, active-high
//   m_line     line drive, active-low
//   result     00 none, 01 miss, 10 hit, 11 invalid
//   hits_left  ship cells not yet hit
//   state      00 IDLE, 01 PLACE, 10 ATTACK, 11 OVER
//   game_over  high while in OVER
// ---------------------------------------------------------------------------
module modulo_batalha_naval_param #(
  parameter int unsigned ROWS      = 7,
  parameter int unsigned COLS      = 5,
  parameter int unsigned MAX_SHIPS = 9,
  parameter int unsigned SCAN_DIV  = 16
) (
  input  logic                             clk,
  input  logic                             Nclr,
  input  logic [1:0]                       mode,
  input  logic [$clog2(ROWS)-1:0]          lin_sel,
  input  logic [$clog2(COLS)-1:0]          col_sel,
  input  logic                             confirm,
  output logic [COLS-1:0]                  m_col,
  output logic [ROWS-1:0]                  m_line,
  output logic [1:0]                       result,
  output logic [$clog2(ROWS*COLS+1)-1:0]   hits_left,
  output logic [1:0]                       state,
  output logic                             game_over
);

  localparam int unsigned LW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned HW = $clog2(ROWS*COLS+1);
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_PLACE  = 2'b01;
  localparam logic [1:0] MODE_ATTACK = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PLACE  = 2'b01,
    S_ATTACK = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  state_t                    state_q;
  logic [ROWS-1:0][COLS-1:0] pos_q;
  logic [ROWS-1:0][COLS-1:0] atk_q;
  logic [HW-1:0]             hits_q;
  logic [1:0]                result_q;
  logic                      game_over_q;

  logic                      s1_q, s2_q, s3_q;
  logic                      pulse_c;
  logic                      in_range_c;
  logic                      cell_pos_c;
  logic                      cell_atk_c;

  logic [PW-1:0]             presc_q, presc_d;
  logic [CW-1:0]             col_q, col_d;
  logic [COLS-1:0]           m_col_q, m_col_d;
  logic [ROWS-1:0]           m_line_q, m_line_d;
  logic                      blink_on_c;

  // Button synchroniser plus edge-detect stage; one pulse per press.
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= confirm;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_c = s2_q & ~s3_q;

  // Selected-cell lookup; out-of-range selections never index the arrays.
  always_comb begin
    in_range_c = (32'(lin_sel) < ROWS) && (32'(col_sel) < COLS);
    cell_pos_c = 1'b0;
    cell_atk_c = 1'b0;
    if (in_range_c) begin
      cell_pos_c = pos_q[lin_sel][col_sel];
      cell_atk_c = atk_q[lin_sel][col_sel];
    end
  end

  // Game FSM with board storage; mode changes win over a coincident pulse.
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      atk_q       <= '0;
      hits_q      <= '0;
      result_q    <= RES_NONE;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pos_q       <= '0;
          atk_q       <= '0;
          hits_q      <= '0;
          result_q    <= RES_NONE;
          game_over_q <= 1'b0;
          if (mode == MODE_PLACE) state_q <= S_PLACE;
        end
        S_PLACE: begin
          if (mode == MODE_IDLE) begin
            state_q <= S_IDLE;
          end else if (mode == MODE_ATTACK && hits_q != '0) begin
            state_q  <= S_ATTACK;
            result_q <= RES_NONE;
          end else if (pulse_c) begin
            if (!in_range_c || cell_pos_c || hits_q == HW'(MAX_SHIPS)) begin
              result_q <= RES_INV;
            end else begin
              pos_q[lin_sel][col_sel] <= 1'b1;
              hits_q                  <= hits_q + HW'(1);
              result_q                <= RES_NONE;
            end
          end
        end
        S_ATTACK: begin
          if (mode == MODE_IDLE) begin
            state_q <= S_IDLE;
          end else if (pulse_c) begin
            if (!in_range_c || cell_atk_c) begin
              result_q <= RES_INV;
            end else begin
              atk_q[lin_sel][col_sel] <= 1'b1;
              if (cell_pos_c) begin
                result_q <= RES_HIT;
                hits_q   <= hits_q - HW'(1);
                // Last ship cell sunk: game ends on this same edge.
                if (hits_q == HW'(1)) begin
                  state_q     <= S_OVER;
                  game_over_q <= 1'b1;
                end
              end else begin
                result_q <= RES_MISS;
              end
            end
          end
        end
        S_OVER: begin
          if (mode == MODE_IDLE) begin
            state_q     <= S_IDLE;
            game_over_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef BLINK_HITS_EN
  logic [19:0] blink_q;

  // Free-running blink timebase for hit cells.
  always_ff @(posedge clk) begin
    if (!Nclr) blink_q <= '0;
    else       blink_q <= blink_q + 20'd1;
  end

  assign blink_on_c = blink_q[19];
`else
  assign blink_on_c = 1'b1;
`endif

  // Scan next-state: column drive and line data are built from the same
  // next column index so both registers switch together.
  always_comb begin
    presc_d = presc_q + PW'(1);
    col_d   = col_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    end
    m_col_d = COLS'(1) << col_d;
    for (int l = 0; l < ROWS; l++) begin
      if (state_q == S_ATTACK || state_q == S_OVER)
        m_line_d[l] = ~(atk_q[l][col_d] & (~pos_q[l][col_d] | blink_on_c));
      else
        m_line_d[l] = ~pos_q[l][col_d];
    end
  end

  // Scan registers.
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      presc_q  <= '0;
      col_q    <= '0;
      m_col_q  <= COLS'(1);
      m_line_q <= '1;
    end else begin
      presc_q  <= presc_d;
      col_q    <= col_d;
      m_col_q  <= m_col_d;
      m_line_q <= m_line_d;
    end
  end

  assign m_col     = m_col_q;
  assign m_line    = m_line_q;
  assign result    = result_q;
  assign hits_left = hits_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_modulo_batalha_naval_param.sv
// Directed bench for modulo_batalha_naval_param (7x5 board, SCAN_DIV=4).
module tb_modulo_batalha_naval_param;

  logic       clk;
  logic       Nclr;
  logic [1:0] mode;
  logic [2:0] lin_sel;
  logic [2:0] col_sel;
  logic       confirm;
  logic [4:0] m_col;
  logic [6:0] m_line;
  logic [1:0] result;
  logic [5:0] hits_left;
  logic [1:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  modulo_batalha_naval_param #(
    .ROWS(7), .COLS(5), .MAX_SHIPS(9), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .Nclr(Nclr), .mode(mode), .lin_sel(lin_sel), .col_sel(col_sel),
    .confirm(confirm), .m_col(m_col), .m_line(m_line), .result(result),
    .hits_left(hits_left), .state(state), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Short press: pulse acts two edges after first sample, then release.
  task automatic press(input logic [2:0] l, input logic [2:0] c);
    lin_sel = l;
    col_sel = c;
    confirm = 1'b1;
    tick(3);
    confirm = 1'b0;
    tick(3);
  endtask

  initial begin
    logic       found;
    logic [4:0] exp_col;
    logic [6:0] exp_line;
    int         cidx;

    Nclr = 1'b0; mode = 2'b00; lin_sel = '0; col_sel = '0; confirm = 1'b0;

    // 1: reset
    tick(2);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_mcol", 32'(m_col), 32'h01);
    chk("rst_mline", 32'(m_line), 32'h7f);
    chk("rst_hits", 32'(hits_left), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_gameover", 32'(game_over), 32'h0);
    Nclr = 1'b1;

    // 2: placement
    mode = 2'b01;
    tick(1);
    chk("place_state", 32'(state), 32'h1);
    press(3'd1, 3'd2);
    chk("place1_hits", 32'(hits_left), 32'd1);
    chk("place1_result", 32'(result), 32'h0);
    press(3'd3, 3'd4);
    chk("place2_hits", 32'(hits_left), 32'd2);
    press(3'd1, 3'd2);
    chk("place_dup_result", 32'(result), 32'h3);
    chk("place_dup_hits", 32'(hits_left), 32'd2);
    press(3'd7, 3'd0);
    chk("place_oor_result", 32'(result), 32'h3);
    chk("place_oor_hits", 32'(hits_left), 32'd2);

    // 5: scan timing and column contents while placing
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_col == 5'b10000) found = 1'b1;
      else tick(1);
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        tick(1);
        if (m_col == 5'b00001) found = 1'b1;
      end
    end
    chk("scan_sync", 32'(found), 32'h1);
    for (int k = 0; k <= 20; k++) begin
      cidx    = (k / 4) % 5;
      exp_col = 5'b00001 << cidx;
      exp_line = (cidx == 2) ? 7'b1111101 : (cidx == 4) ? 7'b1110111 : 7'b1111111;
      chk($sformatf("scan_col_k%0d", k), 32'(m_col), 32'(exp_col));
      chk($sformatf("scan_line_k%0d", k), 32'(m_line), 32'(exp_line));
      tick(1);
    end

    // 3: attack
    mode = 2'b10;
    tick(1);
    chk("atk_state", 32'(state), 32'h2);
    chk("atk_entry_result", 32'(result), 32'h0);
    press(3'd0, 3'd0);
    chk("atk_miss_result", 32'(result), 32'h1);
    chk("atk_miss_hits", 32'(hits_left), 32'd2);
    press(3'd1, 3'd2);
    chk("atk_hit_result", 32'(result), 32'h2);
    chk("atk_hit_hits", 32'(hits_left), 32'd1);
    press(3'd1, 3'd2);
    chk("atk_rep_result", 32'(result), 32'h3);
    chk("atk_rep_hits", 32'(hits_left), 32'd1);
    press(3'd0, 3'd5);
    chk("atk_oor_result", 32'(result), 32'h3);

    // 4: final hit ends the game; later presses are ignored
    press(3'd3, 3'd4);
    chk("over_result", 32'(result), 32'h2);
    chk("over_hits", 32'(hits_left), 32'd0);
    chk("over_state", 32'(state), 32'h3);
    chk("over_gameover", 32'(game_over), 32'h1);
    press(3'd0, 3'd1);
    chk("over_ign_result", 32'(result), 32'h2);
    chk("over_ign_hits", 32'(hits_left), 32'd0);
    chk("over_ign_state", 32'(state), 32'h3);

    // back to IDLE clears everything
    mode = 2'b00;
    tick(2);
    chk("idle_state", 32'(state), 32'h0);
    chk("idle_hits", 32'(hits_left), 32'd0);
    chk("idle_result", 32'(result), 32'h0);
    chk("idle_gameover", 32'(game_over), 32'h0);

    // 6: held button yields one action
    mode = 2'b01;
    tick(1);
    lin_sel = 3'd2; col_sel = 3'd0; confirm = 1'b1;
    tick(50);
    confirm = 1'b0;
    tick(3);
    chk("held_hits", 32'(hits_left), 32'd1);
    chk("held_result", 32'(result), 32'h0);

    // pulse coinciding with mode 01->00 is dropped
    lin_sel = 3'd4; col_sel = 3'd1; confirm = 1'b1;
    tick(2);
    mode = 2'b00;
    tick(1);
    chk("drop_state", 32'(state), 32'h0);
    chk("drop_hits", 32'(hits_left), 32'd1);
    chk("drop_result", 32'(result), 32'h0);
    confirm = 1'b0;
    tick(3);
    chk("drop_idle_hits", 32'(hits_left), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
